ecsu_multi: RTL
===============

Name: ecsu_multi

Overview:
Multi-channel Emergency Climate Sensor Unit, the parametrised successor to the single-sensor ECSU. It classifies NUM_SENSORS weather-sensor channels per cycle and aggregates them into one worst-case severity. A four-state alert FSM is driven by persistence and recovery counters, so a single-cycle glitch cannot escalate or de-escalate it. EMERGENCY is left only by an operator acknowledge. The block sits between the sensor front-ends and the flight-control alert logic.

Parameters:
NUM_SENSORS, 4, number of sensor channels (1..8)
WIND_W, 6, wind speed width per channel (unsigned)
TEMP_W, 8, temperature width per channel (two's complement)
WIND_CAUTION, 10, wind strictly above this gives level 1
WIND_HIGH, 15, wind strictly above this gives level 2
WIND_EMERG, 20, wind strictly above this gives level 3
TEMP_HOT, 35, temperature strictly above this gives level 3 (signed compare)
TEMP_COLD, -35, temperature strictly below this gives level 3 (signed compare)
PERSIST, 3, consecutive qualifying cycles required to escalate one state (>=1)
RECOVER, 4, consecutive qualifying cycles required to de-escalate one state (>=1)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
sensor_valid  in  NUM_SENSORS  per-channel data valid
thunderstorm  in  NUM_SENSORS  per-channel thunderstorm flag
wind  in  NUM_SENSORS*WIND_W  packed wind; channel i is at [i*WIND_W +: WIND_W]
visibility  in  2*NUM_SENSORS  packed visibility codes (00 clear, 01/10 reduced, 11 none)
temperature  in  NUM_SENSORS*TEMP_W  packed signed temperatures
ack_emergency  in  1  operator acknowledge
ECSU_state  out  2  0 ALL_GOOD, 1 CAUTION, 2 HIGH_ALERT, 3 EMERGENCY
severe_weather  out  1  high when state >= HIGH_ALERT
emergency_landing_alert  out  1  high when state == EMERGENCY
worst_sensor  out  max(1,$clog2(NUM_SENSORS))  index of the channel driving the aggregate level
emergency_count  out  8  saturating count of entries into EMERGENCY

Behaviour:
- Reset (RST=0, any time, including mid-escalation): ECSU_state=0, severe_weather=0, emergency_landing_alert=0, worst_sensor=0, emergency_count=0, both counters=0. Reset takes effect asynchronously.
- Per-channel level (combinational; invalid channels are ignored):
  - 3: temp>TEMP_HOT, temp<TEMP_COLD, or wind>WIND_EMERG.
  - else 2: thunderstorm, wind>WIND_HIGH, or visibility==11.
  - else 1: wind>WIND_CAUTION or visibility in {01,10}.
  - else 0.
- Aggregate level agg = maximum over valid channels. Ties go to the lowest index.
- worst_sensor is registered every cycle at which at least one channel is valid. Otherwise it holds its value.
- No valid channel: both counters and the state hold; no transition occurs.
- Escalation counter esc_cnt:
  - Increments on each edge with agg > state (state < 3).
  - At the edge where esc_cnt==PERSIST-1 and the condition still holds: state <= state+1 and esc_cnt <= 0.
  - Escalation is one step per event; there is no skipping.
  - Cleared on any edge with a valid agg <= state.
- Recovery counter rec_cnt (states 1 and 2 only):
  - Increments on each edge with agg < state.
  - At the edge where rec_cnt==RECOVER-1: state <= state-1 and rec_cnt <= 0.
  - Cleared on any edge with a valid agg >= state.
- EMERGENCY:
  - Ignores rec_cnt.
  - Exits to CAUTION on an edge with ack_emergency=1 and a valid agg <= 1. Otherwise it stays, and the ack is dropped (not remembered).
  - ack_emergency is ignored in all other states.
- Entering EMERGENCY increments emergency_count, saturating at 255.
- severe_weather and emergency_landing_alert are registered alongside the state and change on the same edge as ECSU_state.
- Latency: a condition first sampled at edge k changes the state at edge k+PERSIST-1 (escalate) or k+RECOVER-1 (recover).

Test Plan:
1. Apply RST=0 mid-cycle while in HIGH_ALERT with esc_cnt=2 -> all outputs are 0 immediately. After release, wind0=12 is needed for a full 3 edges to reach CAUTION.
2. ch2 wind=12 for 2 edges, then 5 -> state stays 0. Held for 3 edges -> state=1 on the 3rd edge, worst_sensor=2.
3. From CAUTION: ch0 thunderstorm for 3 edges -> state=2, severe_weather=1. Then ch3 temp=-40 for 3 edges -> state=3, alert=1, worst_sensor=3, emergency_count=1.
4. In EMERGENCY with all channels calm for 10 edges and no ack -> state stays 3. Ack with ch1 wind=25 -> state stays 3. Ack with all calm -> state=1 next edge, alert=0, severe_weather=0.
5. HIGH_ALERT with all calm: calm for 3 edges, 1 cycle of visibility=11, then 4 calm edges -> state=1 only on the 4th calm edge after the interruption. 4 more calm edges -> state=0.
6. sensor_valid=0000 for 5 edges in CAUTION with esc_cnt=1 -> state and counters hold. Invalid ch1 with temp=100 and valid channels calm -> no escalation.

Source files
------------

// File: rtl/ecsu_multi.sv
// Multi-channel emergency climate sensor unit.
// Each valid channel is classified into a severity level from 0 to 3. The
// worst level drives a four-state alert FSM. Persistence and recovery counters
// filter single-cycle glitches. EMERGENCY is left only on an operator acknowledge.
module ecsu_multi #(
    parameter int NUM_SENSORS  = 4,
    parameter int WIND_W       = 6,
    parameter int TEMP_W       = 8,
    parameter int WIND_CAUTION = 10,
    parameter int WIND_HIGH    = 15,
    parameter int WIND_EMERG   = 20,
    parameter int TEMP_HOT     = 35,
    parameter int TEMP_COLD    = -35,
    parameter int PERSIST      = 3,
    parameter int RECOVER      = 4,
    localparam int IDX_W       = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_SENSORS-1:0]        sensor_valid,
    input  logic [NUM_SENSORS-1:0]        thunderstorm,
    input  logic [NUM_SENSORS*WIND_W-1:0] wind,
    input  logic [2*NUM_SENSORS-1:0]      visibility,
    input  logic [NUM_SENSORS*TEMP_W-1:0] temperature,
    input  logic                          ack_emergency,
    output logic [1:0]                    ECSU_state,
    output logic                          severe_weather,
    output logic                          emergency_landing_alert,
    output logic [IDX_W-1:0]              worst_sensor,
    output logic [7:0]                    emergency_count
);

    typedef enum logic [1:0] {
        ALL_GOOD   = 2'd0,
        CAUTION    = 2'd1,
        HIGH_ALERT = 2'd2,
        EMERGENCY  = 2'd3
    } state_t;

    localparam int CNT_W = $clog2((PERSIST > RECOVER) ? PERSIST : RECOVER) + 1;
    localparam logic [CNT_W-1:0] ESC_LAST = CNT_W'(PERSIST - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVER - 1);

    localparam logic [WIND_W-1:0]        W_CAUTION = WIND_W'(WIND_CAUTION);
    localparam logic [WIND_W-1:0]        W_HIGH    = WIND_W'(WIND_HIGH);
    localparam logic [WIND_W-1:0]        W_EMERG   = WIND_W'(WIND_EMERG);
    localparam logic signed [TEMP_W-1:0] T_HOT     = TEMP_W'(TEMP_HOT);
    localparam logic signed [TEMP_W-1:0] T_COLD    = TEMP_W'(TEMP_COLD);

    state_t           state;
    logic [CNT_W-1:0] esc_cnt;
    logic [CNT_W-1:0] rec_cnt;
    logic [1:0]       agg;
    logic [IDX_W-1:0] agg_idx;
    logic             any_valid;

    // Severity of one channel, highest matching rule wins.
    function automatic logic [1:0] chan_level(input logic ts,
                                              input logic [WIND_W-1:0] w,
                                              input logic [1:0] vis,
                                              input logic signed [TEMP_W-1:0] t);
        if (t > T_HOT || t < T_COLD || w > W_EMERG)
            return 2'd3;
        else if (ts || w > W_HIGH || vis == 2'b11)
            return 2'd2;
        else if (w > W_CAUTION || vis == 2'b01 || vis == 2'b10)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    // Saturating increment for the emergency entry counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic state_t step_up(input state_t s);
        case (s)
            ALL_GOOD: return CAUTION;
            CAUTION:  return HIGH_ALERT;
            default:  return EMERGENCY;
        endcase
    endfunction

    function automatic state_t step_down(input state_t s);
        return (s == HIGH_ALERT) ? CAUTION : ALL_GOOD;
    endfunction

    // Worst level over valid channels; strict compare keeps the lowest index on ties.
    always_comb begin
        logic [1:0] lvl;
        agg       = 2'd0;
        agg_idx   = '0;
        any_valid = 1'b0;
        lvl       = 2'd0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            lvl = chan_level(thunderstorm[i], wind[i*WIND_W +: WIND_W],
                             visibility[2*i +: 2],
                             $signed(temperature[i*TEMP_W +: TEMP_W]));
            if (sensor_valid[i] && (!any_valid || lvl > agg)) begin
                agg     = lvl;
                agg_idx = IDX_W'(i);
            end
            if (sensor_valid[i])
                any_valid = 1'b1;
        end
    end

    assign ECSU_state = state;

    // Alert FSM with persistence/recovery counters; everything holds when no channel is valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state                   <= ALL_GOOD;
            esc_cnt                 <= '0;
            rec_cnt                 <= '0;
            severe_weather          <= 1'b0;
            emergency_landing_alert <= 1'b0;
            worst_sensor            <= '0;
            emergency_count         <= 8'd0;
        end else if (any_valid) begin
            worst_sensor <= agg_idx;
            if (state == EMERGENCY) begin
                esc_cnt <= '0;
                rec_cnt <= '0;
                if (ack_emergency && agg <= 2'd1) begin
                    state                   <= CAUTION;
                    severe_weather          <= 1'b0;
                    emergency_landing_alert <= 1'b0;
                end
            end else if (agg > state) begin
                rec_cnt <= '0;
                if (esc_cnt == ESC_LAST) begin
                    esc_cnt                 <= '0;
                    state                   <= step_up(state);
                    severe_weather          <= (state != ALL_GOOD);
                    emergency_landing_alert <= (state == HIGH_ALERT);
                    if (state == HIGH_ALERT)
                        emergency_count <= sat_inc8(emergency_count);
                end else begin
                    esc_cnt <= esc_cnt + CNT_W'(1);
                end
            end else if (agg < state) begin
                esc_cnt <= '0;
                if (rec_cnt == REC_LAST) begin
                    rec_cnt                 <= '0;
                    state                   <= step_down(state);
                    severe_weather          <= 1'b0;
                    emergency_landing_alert <= 1'b0;
                end else begin
                    rec_cnt <= rec_cnt + CNT_W'(1);
                end
            end else begin
                esc_cnt <= '0;
                rec_cnt <= '0;
            end
        end
    end

endmodule
